fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Sequences the shared 16x16 signed ALU to compute one N-tap FIR output per accepted input sample. Holds the coefficient register file and the sample delay line. Issues one multiply per cycle to the ALU and accumulates the returned products into a 32-bit sum. Sits between the sample source and the output sink, and is the ALU's only driver in the FIR core.

Parameters:
NTAPS, 8, number of taps; power of two, 2..64
ALU_LAT, 1, cycles from an ALU operand cycle to its valid result; 0..4
COEF_AW, 3, coefficient address width; must equal clog2(NTAPS)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset; also routed to the ALU rst
in_valid  in  1  sample valid
in_ready  out  1  sequencer can accept a sample
in_data  in  16  signed input sample
out_valid  out  1  filtered result valid
out_ready  in  1  sink accepts result
out_data  out  32  signed filter output y
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  COEF_AW  tap index
coef_wr_data  in  16  signed coefficient
flush  in  1  clear the delay line
busy  out  1  high in any state other than IDLE
alu_op_sel  out  2  ALU operation select
alu_a  out  16  ALU operand a (coefficient)
alu_b  out  16  ALU operand b (sample)
alu_result  in  32  ALU result

Behaviour:
- Reset (rst=1 at an edge) does the following, including mid-computation:
  - state becomes IDLE
  - all coefficients and delay-line entries become 0
  - accumulator and out_data become 0
  - out_valid=0, in_ready=1, busy=0
  - alu_a=alu_b=0, alu_op_sel=OP_MUL
- States and transitions:
  - IDLE -> ISSUE on in_valid&&in_ready
  - ISSUE -> DRAIN after tap NTAPS-1 is issued
  - DRAIN -> DONE after the last product is accumulated
  - DONE -> IDLE on out_valid&&out_ready
- in_ready is 1 only in IDLE. busy = (state != IDLE).
- Accept cycle T:
  - the shift happens at the end of T: x[0] <= in_data, x[k] <= x[k-1]
  - accumulator <= 0
- ISSUE, cycles T+1 .. T+NTAPS:
  - in cycle T+1+k, drive alu_op_sel=OP_MUL, alu_a=coef[k], alu_b=x[k]
- Product collection:
  - the product for tap k is on alu_result in cycle T+1+k+ALU_LAT
  - it is added to the accumulator at the end of that cycle
  - collection is counter-tracked and independent of the issue counter
- Timing:
  - out_valid rises in cycle T+NTAPS+ALU_LAT+1 (T+10 for the defaults)
  - out_data = sum over k of coef[k]*x[k]
  - the sum is 32-bit two's-complement with wrap-around; no saturation
- Outside ISSUE: alu_a=alu_b=0 and alu_op_sel=OP_MUL. Op codes 01 and 10 are never issued.
- DONE:
  - out_valid and out_data stay stable while out_ready=0
  - after the handshake, out_valid=0 next cycle and the state is IDLE
  - minimum spacing between accepts is NTAPS+ALU_LAT+2 cycles
- Coefficient writes:
  - take effect only in IDLE, visible from the next cycle
  - ignored (dropped) in any other state
- flush:
  - only acts in IDLE; zeroes all x[k] at the end of the cycle; ignored otherwise
  - flush together with an in_valid accept: flush wins, the sample is not accepted, in_ready remains 1
- coef_wr_en together with an accept in IDLE: the write completes, and the computation uses the old coefficient value.

Decomposition:
- Shared package/include fir_pkg holds:
  - OP_MUL=2'b00, OP_ADD=2'b01, OP_SUB=2'b10
  - state encodings ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE
  - SAMPLE_W=16, ACC_W=32
- One natural sub-module: fir_delay_line. It is an NTAPS x 16 shift register with shift, flush and rst inputs, plus a read mux indexed by tap.

Test Plan:
- Impulse response: coef[k]=k+1; inputs 1,0,0,...,0 (9 samples) -> out_data = 1,2,3,4,5,6,7,8,0. out_valid at exactly T+10 after each accept.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_data stable throughout, in_ready=0, no ALU ops issued. A sample presented during that time is not accepted until after the handshake.
- Wrap boundary:
  - all coef=16'sh8000, all samples 16'sh8000 -> each product 32'h40000000, sum of 8 wraps to 32'h00000000
  - all coef and samples 16'sh7FFF -> out_data = 32'hFFF80008
- Coefficient write while busy: write coef[0]=100 during ISSUE -> ignored, result uses the old coef[0]. The same write in IDLE applies to the next sample.
- Flush and simultaneous events: a flush+in_valid cycle clears the delay line and does not accept the sample. The next impulse then yields the clean 1..8 sequence.
- Reset mid-operation: assert rst in ISSUE cycle 4 -> next cycle IDLE, out_valid=0, coefficients=0. After new coefficient loads and an impulse, the output is correct with no stale products.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR core types: ALU op codes, sequencer states, datapath widths.
// Pure declarations; no latency or flow-control behaviour of its own.
package fir_pkg;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep sample shift register with clear and a tap-indexed read mux.
// Shift/flush take effect at the clock edge; read is combinational; no backpressure.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int IDX_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       shift,
    input  logic                       flush,
    input  logic signed [SAMPLE_W-1:0] din,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic signed [SAMPLE_W-1:0] rd_data
);

    logic signed [SAMPLE_W-1:0] x [NTAPS];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < NTAPS; k++) x[k] <= '0;
        end else if (shift) begin
            x[0] <= din;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        end
    end

    assign rd_data = x[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Drives the shared ALU with one coef*sample multiply per cycle and sums the products into one FIR output.
// Result valid NTAPS+ALU_LAT+1 cycles after accept; in_ready low until the result is taken by the sink.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS   = 8,
    parameter int ALU_LAT = 1,
    parameter int COEF_AW = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    out_data,
    input  logic                       coef_wr_en,
    input  logic [COEF_AW-1:0]         coef_wr_addr,
    input  logic signed [SAMPLE_W-1:0] coef_wr_data,
    input  logic                       flush,
    output logic                       busy,
    output logic [1:0]                 alu_op_sel,
    output logic signed [SAMPLE_W-1:0] alu_a,
    output logic signed [SAMPLE_W-1:0] alu_b,
    input  logic signed [ACC_W-1:0]    alu_result
);

    state_t state, state_nxt;

    logic signed [SAMPLE_W-1:0] coef [NTAPS];
    logic [COEF_AW-1:0]         iss_cnt;
    logic [COEF_AW-1:0]         col_cnt;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] x_rd;

    // Old value of a coefficient overwritten in the accept cycle; the
    // computation already in flight must still see it.
    logic                       shadow_vld;
    logic [COEF_AW-1:0]         shadow_addr;
    logic signed [SAMPLE_W-1:0] shadow_dat;

    logic is_idle, accept, issuing, last_iss, prod_vld, last_col;

    assign is_idle  = (state == ST_IDLE);
    assign accept   = is_idle && in_valid && !flush;
    assign issuing  = (state == ST_ISSUE);
    assign last_iss = issuing && (iss_cnt == COEF_AW'(NTAPS - 1));
    assign last_col = prod_vld && (col_cnt == COEF_AW'(NTAPS - 1));

    // Products are tracked by delaying the issue strobe by the ALU latency.
    generate
        if (ALU_LAT == 0) begin : g_nolat
            assign prod_vld = issuing;
        end else begin : g_lat
            logic [ALU_LAT-1:0] pipe_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q[0] <= issuing;
                    for (int i = 1; i < ALU_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign prod_vld = pipe_q[ALU_LAT-1];
        end
    endgenerate

    fir_delay_line #(
        .NTAPS (NTAPS),
        .IDX_W (COEF_AW)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .shift   (accept),
        .flush   (is_idle && flush),
        .din     (in_data),
        .rd_idx  (iss_cnt),
        .rd_data (x_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        alu_op_sel = OP_MUL;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                alu_a = (shadow_vld && shadow_addr == iss_cnt) ? shadow_dat : coef[iss_cnt];
                alu_b = x_rd;
                if (last_iss) state_nxt = last_col ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_col) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_valid && out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
            iss_cnt     <= '0;
            col_cnt     <= '0;
            acc         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            shadow_vld  <= 1'b0;
            shadow_addr <= '0;
            shadow_dat  <= '0;
        end else begin
            if (is_idle) begin
                shadow_vld  <= accept && coef_wr_en;
                shadow_addr <= coef_wr_addr;
                shadow_dat  <= coef[coef_wr_addr];
                if (coef_wr_en) coef[coef_wr_addr] <= coef_wr_data;
            end
            if (accept) begin
                iss_cnt <= '0;
                col_cnt <= '0;
                acc     <= '0;
            end
            if (issuing) iss_cnt <= iss_cnt + 1'b1;
            if (prod_vld) begin
                acc     <= acc + alu_result;
                col_cnt <= col_cnt + 1'b1;
                if (last_col) begin
                    out_data  <= acc + alu_result;
                    out_valid <= 1'b1;
                end
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: ALU model plus an array-based FIR reference,
// directed corner cases followed by randomized samples and coefficient updates.
module tb_fir_mac_sequencer;

    localparam int NT  = 8;
    localparam int LAT = 1;
    localparam int AW  = 3;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic               coef_wr_en;
    logic [AW-1:0]      coef_wr_addr;
    logic signed [15:0] coef_wr_data;
    logic               flush;
    logic               busy;
    logic [1:0]         alu_op_sel;
    logic signed [15:0] alu_a;
    logic signed [15:0] alu_b;
    logic signed [31:0] alu_result;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] mc [NT];
    logic signed [15:0] mx [NT];

    fir_mac_sequencer #(.NTAPS(NT), .ALU_LAT(LAT), .COEF_AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .flush        (flush),
        .busy         (busy),
        .alu_op_sel   (alu_op_sel),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU with a single result register.
    always @(posedge clk) begin
        if (rst) alu_result <= 32'sd0;
        else case (alu_op_sel)
            2'b00:   alu_result <= int'(alu_a) * int'(alu_b);
            2'b01:   alu_result <= int'(alu_a) + int'(alu_b);
            2'b10:   alu_result <= int'(alu_a) - int'(alu_b);
            default: alu_result <= 32'sd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear_x();
        for (int k = 0; k < NT; k++) mx[k] = 16'sd0;
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic signed [15:0] d);
        coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
        @(posedge clk); #1;
        coef_wr_en = 1'b0;
        mc[a] = d;
    endtask

    task automatic do_flush(input logic with_valid);
        flush = 1'b1; in_valid = with_valid; in_data = 16'sd5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_rdy", in_ready, 1);
        chk("flush_busy", busy, 0);
        model_clear_x();
    endtask

    // wr_mode: 0 none, 1 coef write during ISSUE (must be dropped), 2 write in the accept cycle
    task automatic send(input logic signed [15:0] d, input int hold, input int wr_mode,
                        input logic [AW-1:0] wa, input logic signed [15:0] wd,
                        input logic has_exp, input logic [31:0] exp_c);
        int n;
        int s;
        logic got;
        logic [31:0] held;
        logic signed [15:0] cu [NT];
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("idle_rdy", in_ready, 1);
        in_valid = 1'b1; in_data = d;
        if (wr_mode == 2) begin coef_wr_en = 1'b1; coef_wr_addr = wa; coef_wr_data = wd; end
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = d;
        cu = mc;
        s = 0;
        for (int k = 0; k < NT; k++) s += int'(mc[k]) * int'(mx[k]);
        if (wr_mode == 2) mc[wa] = wd;
        @(posedge clk); #1;
        in_valid = 1'b0; coef_wr_en = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
                chk("latency", i, NT + LAT + 1);
            end else begin
                if (i - 1 < NT) begin
                    chk("alu_a", alu_a, cu[i-1]);
                    chk("alu_b", alu_b, mx[i-1]);
                    chk("alu_op", alu_op_sel, 0);
                end else begin
                    chk("drain_a", alu_a, 0);
                end
                if (wr_mode == 1 && i == 3) begin
                    coef_wr_en = 1'b1; coef_wr_addr = wa; coef_wr_data = wd;
                end else begin
                    coef_wr_en = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        coef_wr_en = 1'b0;
        if (!got) chk("out_timeout", 0, 1);
        chk("y", out_data, has_exp ? exp_c : s);
        chk("done_busy", busy, 1);
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_vld", out_valid, 1);
            chk("bp_dat", out_data, held);
            chk("bp_rdy", in_ready, 0);
            chk("bp_alu", {alu_a, alu_b}, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_vld", out_valid, 0);
        chk("hs_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; flush = 1'b0;
        for (int k = 0; k < NT; k++) mc[k] = 16'sd0;
        model_clear_x();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_vld", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_alu", {alu_a, alu_b}, 0);
        chk("rst_op", alu_op_sel, 0);

        // Impulse response with back-pressure on the fourth output
        for (int k = 0; k < NT; k++) write_coef(AW'(k), 16'(k + 1));
        for (int i = 0; i <= NT; i++)
            send(i == 0 ? 16'sd1 : 16'sd0, i == 3 ? 5 : 0, 0, 0, 0, 1, i < NT ? i + 1 : 0);

        // Wrap-around boundaries
        for (int k = 0; k < NT; k++) write_coef(AW'(k), 16'sh8000);
        for (int i = 0; i < NT - 1; i++) send(16'sh8000, 0, 0, 0, 0, 0, 0);
        send(16'sh8000, 0, 0, 0, 0, 1, 32'h00000000);
        for (int k = 0; k < NT; k++) write_coef(AW'(k), 16'sh7FFF);
        for (int i = 0; i < NT - 1; i++) send(16'sh7FFF, 0, 0, 0, 0, 0, 0);
        send(16'sh7FFF, 0, 0, 0, 0, 1, 32'hFFF80008);

        // Coefficient writes while busy, in IDLE, and together with an accept
        for (int k = 0; k < NT; k++) write_coef(AW'(k), 16'(k + 1));
        send(16'sd300, 0, 1, 0, 16'sd100, 0, 0);
        write_coef(0, 16'sd100);
        send(-16'sd45, 0, 0, 0, 0, 0, 0);
        send(16'sd77, 1, 2, 1, -16'sd7, 0, 0);
        send(16'sd12, 0, 0, 0, 0, 0, 0);

        // Flush beats a simultaneous sample; clean impulse afterwards
        for (int k = 0; k < NT; k++) write_coef(AW'(k), 16'(k + 1));
        do_flush(1'b1);
        for (int i = 0; i < NT; i++)
            send(i == 0 ? 16'sd1 : 16'sd0, 0, 0, 0, 0, 1, i + 1);

        // Reset during the fourth ISSUE cycle
        in_valid = 1'b1; in_data = 16'sd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_rdy", in_ready, 1);
        chk("mrst_dat", out_data, 0);
        for (int k = 0; k < NT; k++) mc[k] = 16'sd0;
        model_clear_x();
        send(16'sd9, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < NT; k++) write_coef(AW'(k), 16'(k + 1));
        do_flush(1'b0);
        send(16'sd1, 0, 0, 0, 0, 1, 1);
        send(16'sd0, 0, 0, 0, 0, 1, 2);

        // Randomized traffic
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 2) == 0) write_coef(AW'($urandom_range(0, NT - 1)), 16'($urandom));
            if ($urandom_range(0, 7) == 0) do_flush(1'($urandom_range(0, 1)));
            send(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                 AW'($urandom_range(0, NT - 1)), 16'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
